// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I memory-access stage and MEM/WB pipeline register.
// The data-memory side is combinational: word address, byte enables,
// store-data lane steering and load extraction. The W-side outputs are
// registered with reset > flush > stall > capture priority.
// Optional feature: define MISALIGN_TRAP_EN to suppress misaligned
// half/word accesses and report them on the registered MisalignW output.
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      StallW,
    input  logic                      FlushW,
    input  logic                      RegWriteM,
    input  logic [1:0]                ResultSrcM,
    input  logic                      MemWriteM,
    input  logic [2:0]                Funct3M,
    input  logic [DATA_WIDTH-1:0]     ALUResultM,
    input  logic [DATA_WIDTH-1:0]     WriteDataM,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0]     PCPlus4M,
    output logic [DATA_WIDTH-1:0]     DataAdrM,
    output logic [DATA_WIDTH-1:0]     DataWDataM,
    output logic [3:0]                ByteEnM,
    output logic                      MemWEnM,
    input  logic [DATA_WIDTH-1:0]     ReadRawM,
    output logic                      RegWriteW,
    output logic [1:0]                ResultSrcW,
    output logic [DATA_WIDTH-1:0]     ALUResultW,
    output logic [DATA_WIDTH-1:0]     ReadDataW,
    output logic [DATA_WIDTH-1:0]     PCPlus4W,
    output logic [REG_ADDR_WIDTH-1:0] RdW
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                      MisalignW
`endif
);

    logic [1:0]            off_s;
    logic [3:0]            lanes_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic                  misalign_s;

    // Select the addressed lane and sign- or zero-extend it by funct3.
    function automatic logic [31:0] extend_load(
        input logic [2:0]  f3,
        input logic [31:0] raw,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        h = 16'h0000;
        r = 32'h0000_0000;
        case (off)
            2'b00:   b = raw[7:0];
            2'b01:   b = raw[15:8];
            2'b10:   b = raw[23:16];
            default: b = raw[31:24];
        endcase
        if (off[1]) begin
            h = raw[31:16];
        end else begin
            h = raw[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Detect misaligned half/word memory accesses (only when the trap is built in).
    always_comb begin
        off_s = ALUResultM[1:0];
`ifdef MISALIGN_TRAP_EN
        if (MemWriteM || (ResultSrcM == 2'b01)) begin
            misalign_s = ((Funct3M[1:0] == 2'b01) && off_s[0]) ||
                         ((Funct3M == 3'b010) && (off_s != 2'b00));
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
    end

    // Store byte enables, lane steering and word address toward data memory.
    always_comb begin
        DataAdrM   = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
        lanes_s    = 4'b0000;
        DataWDataM = WriteDataM;
        case (Funct3M)
            3'b000: begin
                lanes_s    = 4'b0001 << off_s;
                DataWDataM = {4{WriteDataM[7:0]}};
            end
            3'b001: begin
                if (off_s[1]) begin
                    lanes_s = 4'b1100;
                end else begin
                    lanes_s = 4'b0011;
                end
                DataWDataM = {2{WriteDataM[15:0]}};
            end
            3'b010: begin
                lanes_s    = 4'b1111;
                DataWDataM = WriteDataM;
            end
            default: begin
                lanes_s    = 4'b0000;
                DataWDataM = WriteDataM;
            end
        endcase
        if (MemWriteM && !misalign_s) begin
            ByteEnM = lanes_s;
        end else begin
            ByteEnM = 4'b0000;
        end
        MemWEnM = MemWriteM & (|ByteEnM);
    end

    // Extract the load lane from the raw memory word every cycle.
    always_comb begin
        load_data_s = extend_load(Funct3M, ReadRawM, off_s);
    end

    // MEM/WB register: reset, then flush, then stall-hold, else capture.
    always_ff @(posedge clk) begin
        if (reset || FlushW) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= {DATA_WIDTH{1'b0}};
            ReadDataW  <= {DATA_WIDTH{1'b0}};
            PCPlus4W   <= {DATA_WIDTH{1'b0}};
            RdW        <= {REG_ADDR_WIDTH{1'b0}};
`ifdef MISALIGN_TRAP_EN
            MisalignW  <= 1'b0;
`endif
        end else if (!StallW) begin
            RegWriteW  <= RegWriteM & ~misalign_s;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data_s;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
`ifdef MISALIGN_TRAP_EN
            MisalignW  <= misalign_s;
`endif
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. The stimulus process
// drives M inputs shortly after each rising edge and pushes the expected
// memory-side and W-side responses; two monitors pop and compare them.
// Works with or without MISALIGN_TRAP_EN defined.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, StallW, FlushW, RegWriteM, MemWriteM;
    logic [1:0]    ResultSrcM;
    logic [2:0]    Funct3M;
    logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M, ReadRawM;
    logic [RW-1:0] RdM;
    logic [DW-1:0] DataAdrM, DataWDataM;
    logic [3:0]    ByteEnM;
    logic          MemWEnM;
    logic          RegWriteW;
    logic [1:0]    ResultSrcW;
    logic [DW-1:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [RW-1:0] RdW;
`ifdef MISALIGN_TRAP_EN
    logic          MisalignW;
`endif

    mem_wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M), .DataAdrM(DataAdrM),
        .DataWDataM(DataWDataM), .ByteEnM(ByteEnM), .MemWEnM(MemWEnM),
        .ReadRawM(ReadRawM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW)
`ifdef MISALIGN_TRAP_EN
        , .MisalignW(MisalignW)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [3:0]  be;
        logic        wen;
    } mem_t;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        mis;
    } w_t;

    mem_t mem_q[$];
    w_t   w_q[$];
    w_t   w_m;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Loaded value from the spec's lane rules, using shifts and arithmetic.
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] raw, input int off);
        int unsigned b;
        int unsigned h;
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    // Compute expectations for the inputs currently driven, then advance a cycle.
    task automatic step();
        mem_t m;
        w_t   n;
        int   off;
        bit   mis;
        bit   is_mem;
        off      = int'(ALUResultM % 4);
        is_mem   = MemWriteM || (ResultSrcM == 2'd1);
        mis      = is_mem && ((((Funct3M == 3'd1) || (Funct3M == 3'd5)) && (off % 2 == 1)) ||
                              ((Funct3M == 3'd2) && (off != 0)));
        m.adr       = ALUResultM - (ALUResultM % 4);
        m.be        = 4'd0;
        m.wdata     = 32'd0;
        m.chk_wdata = 1'b0;
        if (MemWriteM) begin
            case (Funct3M)
                3'd0: begin
                    m.be = 4'(1 << off);
                    m.wdata = 32'(WriteDataM[7:0]) * 32'h0101_0101;
                    m.chk_wdata = 1'b1;
                end
                3'd1: begin
                    m.be = 4'(3 << (2 * (off / 2)));
                    m.wdata = 32'(WriteDataM[15:0]) * 32'h0001_0001;
                    m.chk_wdata = 1'b1;
                end
                3'd2: begin
                    m.be = 4'hF;
                    m.wdata = WriteDataM;
                    m.chk_wdata = 1'b1;
                end
                default: m.be = 4'd0;
            endcase
        end
        if (TRAP && mis) m.be = 4'd0;
        m.wen = (m.be != 4'd0);

        if (reset || FlushW) begin
            n = '{rw: 1'b0, rs: 2'd0, alu: 32'd0, rdata: 32'd0, pc4: 32'd0, rd: 5'd0, mis: 1'b0};
        end else if (StallW) begin
            n = w_m;
        end else begin
            n.rw    = RegWriteM && !(TRAP && mis);
            n.rs    = ResultSrcM;
            n.alu   = ALUResultM;
            n.rdata = ld_model(Funct3M, ReadRawM, off);
            n.pc4   = PCPlus4M;
            n.rd    = RdM;
            n.mis   = TRAP && mis;
        end
        mem_q.push_back(m);
        w_q.push_back(n);
        w_m = n;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_m();
        reset = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        RegWriteM = 1'b0; ResultSrcM = 2'd0; MemWriteM = 1'b0; Funct3M = 3'd0;
        ALUResultM = 32'd0; WriteDataM = 32'd0; RdM = 5'd0; PCPlus4M = 32'd0;
        ReadRawM = 32'd0;
    endtask

    task automatic rand_m();
        RegWriteM  = 1'($urandom);
        ResultSrcM = 2'($urandom);
        MemWriteM  = 1'($urandom);
        Funct3M    = 3'($urandom);
        ALUResultM = $urandom;
        WriteDataM = $urandom;
        RdM        = 5'($urandom);
        PCPlus4M   = $urandom;
        ReadRawM   = $urandom;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] adr);
        clear_m();
        RegWriteM = 1'b1; ResultSrcM = 2'd1; Funct3M = f3; ALUResultM = adr;
        RdM = 5'd9; ReadRawM = 32'h80FF_7F01;
        step();
    endtask

    // Memory-side monitor: combinational outputs are stable by the falling edge.
    always @(negedge clk) begin : mem_mon
        mem_t e;
        if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            check("DataAdrM", DataAdrM, e.adr);
            check("ByteEnM", 32'(ByteEnM), 32'(e.be));
            check("MemWEnM", 32'(MemWEnM), 32'(e.wen));
            if (e.chk_wdata) check("DataWDataM", DataWDataM, e.wdata);
        end
    end

    // W-side monitor: one expected entry per rising edge, checked just after it.
    always @(posedge clk) begin : w_mon
        w_t e;
        #1;
        if (w_q.size() > 0) begin
            e = w_q.pop_front();
            check("RegWriteW", 32'(RegWriteW), 32'(e.rw));
            check("ResultSrcW", 32'(ResultSrcW), 32'(e.rs));
            check("ALUResultW", ALUResultW, e.alu);
            check("ReadDataW", ReadDataW, e.rdata);
            check("PCPlus4W", PCPlus4W, e.pc4);
            check("RdW", 32'(RdW), 32'(e.rd));
`ifdef MISALIGN_TRAP_EN
            check("MisalignW", 32'(MisalignW), 32'(e.mis));
`endif
        end
    end

    initial begin
        clear_m();
        reset = 1'b1;
        w_m = '{rw: 1'b0, rs: 2'd0, alu: 32'd0, rdata: 32'd0, pc4: 32'd0, rd: 5'd0, mis: 1'b0};
        @(posedge clk);
        #2;

        // Reset with random M inputs, including a store that must still strobe.
        for (int i = 0; i < 2; i++) begin
            rand_m();
            reset = 1'b1;
            step();
        end

        // First capture after release.
        clear_m();
        RegWriteM = 1'b1; RdM = 5'd5; ALUResultM = 32'h0000_1234;
        step();

        // SB at offset 3.
        clear_m();
        MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h0000_0103;
        WriteDataM = 32'hAABB_CCDD;
        step();

        // SH at both halves, SW aligned.
        clear_m();
        MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h0000_0202; WriteDataM = 32'h1234_5678;
        step();
        ALUResultM = 32'h0000_0200;
        step();
        Funct3M = 3'b010; WriteDataM = 32'hCAFE_F00D;
        step();

        // Loads from a fixed raw word.
        do_load(3'b000, 32'h0000_0203);
        do_load(3'b100, 32'h0000_0203);
        do_load(3'b001, 32'h0000_0202);
        do_load(3'b101, 32'h0000_0200);
        do_load(3'b010, 32'h0000_0200);
        do_load(3'b110, 32'h0000_0200);

        // Stall for three cycles while M changes, then flush together with stall.
        do_load(3'b010, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            rand_m();
            StallW = 1'b1;
            step();
        end
        rand_m();
        StallW = 1'b1; FlushW = 1'b1;
        step();

        // JAL result path.
        clear_m();
        RegWriteM = 1'b1; ResultSrcM = 2'b10; PCPlus4M = 32'h0000_0044; RdM = 5'd1;
        step();
        clear_m();
        step();

        // Misaligned SW and LH.
        clear_m();
        MemWriteM = 1'b1; RegWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0102;
        WriteDataM = 32'h0BAD_BEEF; RdM = 5'd3;
        step();
        do_load(3'b001, 32'h0000_0101);

        // Randomized traffic with occasional stall, flush and reset.
        for (int i = 0; i < 400; i++) begin
            rand_m();
            StallW = ($urandom_range(0, 3) == 0);
            FlushW = ($urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 49) == 0);
            step();
        end

        clear_m();
        step();
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the RV32I pipeline.
- Takes EX/MEM-registered controls and data.
- Drives the data-memory port with byte enables and store-data lane steering.
- Extracts and sign/zero-extends load data, then registers everything into the W-stage signals consumed by writeback and the register file.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported (byte-lane logic is fixed at 4 lanes).
- REG_ADDR_WIDTH, 5, destination-register index width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- StallW  input  1  hold MEM/WB register contents.
- FlushW  input  1  load a bubble into MEM/WB.
- RegWriteM  input  1  register-write enable from EX/MEM.
- ResultSrcM  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 zero.
- MemWriteM  input  1  store enable.
- Funct3M  input  3  load/store size and signedness.
- ALUResultM  input  DATA_WIDTH  effective address / ALU result.
- WriteDataM  input  DATA_WIDTH  store data (rs2).
- RdM  input  REG_ADDR_WIDTH  destination register.
- PCPlus4M  input  DATA_WIDTH  PC+4 of the instruction.
- DataAdrM  output  DATA_WIDTH  word address to memory = {ALUResultM[31:2],2'b00}.
- DataWDataM  output  DATA_WIDTH  lane-steered store data.
- ByteEnM  output  4  byte-write enables.
- MemWEnM  output  1  memory write strobe.
- ReadRawM  input  DATA_WIDTH  memory read word, valid combinationally in the same cycle.
- RegWriteW  output  1  registered RegWrite.
- ResultSrcW  output  2  registered ResultSrc.
- ALUResultW  output  DATA_WIDTH  registered ALU result.
- ReadDataW  output  DATA_WIDTH  registered, extended load data.
- PCPlus4W  output  DATA_WIDTH  registered PC+4.
- RdW  output  REG_ADDR_WIDTH  registered destination.

Behaviour:
- Memory side is combinational; W outputs change only on the rising edge. Latency is 1 cycle, M to W.
- Byte offset off = ALUResultM[1:0].
- Store byte-enable and lane steering, when MemWriteM=1:
  - SB (000): ByteEnM = 0001<<off; DataWDataM = {4{WriteDataM[7:0]}}.
  - SH (001): ByteEnM = 0011<<(off[1]*2); DataWDataM = {2{WriteDataM[15:0]}}.
  - SW (010): ByteEnM = 1111; DataWDataM = WriteDataM.
  - Other funct3: ByteEnM = 0000.
- MemWEnM = MemWriteM & |ByteEnM. When MemWriteM=0: ByteEnM = 0000, MemWEnM = 0.
- Load extraction (computed every cycle, meaningful when ResultSrcM=01):
  - LB: sign-extend byte at lane off.
  - LH: sign-extend half at lane off[1].
  - LW: full word.
  - LBU / LHU: zero-extend the same lanes.
  - Funct3 011/110/111: treated as LW.
- Misaligned half (off[0]=1) or word (off≠00) accesses use the truncated lane index; no trap unless the optional feature is on.
- Register update priority, highest first: reset > FlushW > StallW > normal load.
  - reset: all W outputs = 0.
  - FlushW: RegWriteW = 0, ResultSrcW = 00, RdW = 0; data fields = 0.
  - StallW: all W outputs hold.
  - Normal: capture the M values.
- FlushW and StallW asserted together: flush wins.
- Stores are never suppressed by StallW or FlushW. Those act on W only; M-side gating belongs to the hazard unit.
- Reset mid-store: the memory strobe still follows the current M inputs. The W register clears on that edge.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- When defined:
  - Adds output MisalignW (1 bit, registered, reset 0).
  - A misaligned LH/LHU/SH (off[0]=1) or LW/SW (off≠00) forces ByteEnM = 0000 and MemWEnM = 0.
  - The W capture forces RegWriteW = 0 and MisalignW = 1 for that instruction.
  - MisalignW follows the same flush/stall/reset rules as the other W fields.
- When undefined: port absent; misaligned accesses behave as described under Behaviour.

Test Plan:
- Reset: reset=1 for 2 cycles with random M inputs -> all W outputs 0; after release, RegWriteM=1, RdM=5, ALUResultM=0x1234 -> next edge RegWriteW=1, RdW=5, ALUResultW=0x1234.
- SB: ALUResultM=0x103, WriteDataM=0xAABBCCDD, Funct3M=000, MemWriteM=1 -> ByteEnM=1000, DataWDataM=0xDDDDDDDD, DataAdrM=0x100, MemWEnM=1.
- Loads with ReadRawM=0x80FF7F01:
  - LB off=3 -> ReadDataW=0xFFFFFF80.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Stall/flush: StallW=1 for 3 cycles while M changes -> W holds; then FlushW=1 with StallW=1 -> RegWriteW=0, RdW=0 on that edge.
- JAL path: ResultSrcM=10, PCPlus4M=0x44 -> ResultSrcW=10, PCPlus4W=0x44 one cycle later; MemWEnM=0 throughout.
- With MISALIGN_TRAP_EN: SW at ALUResultM=0x102 -> MemWEnM=0, ByteEnM=0000; next edge MisalignW=1, RegWriteW=0.
